// File: rtl/game_pkg.sv
// ============================================================================
// Module      : game_pkg
// Description : Shared state encoding and timing defaults for hit handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

  localparam int DEFAULT_IMMUNE_FRAMES = 120;
  localparam int DEFAULT_BLINK_FRAMES  = 8;
  localparam int FRAME_CNT_W           = 8;

  typedef enum logic [1:0] {
    VULNERABLE = 2'd0,
    HIT        = 2'd1,
    IMMUNE     = 2'd2,
    DEAD       = 2'd3
  } hit_state_t;

  // States in which the lives counter must be left alone.
  function automatic logic is_immortal_state(input hit_state_t s);
    return (s == IMMUNE) || (s == DEAD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_timer.sv
// ============================================================================
// Module      : frame_timer
// Description : Counts video frames during invulnerability and produces the
//               expiry flag and the sprite blink phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_timer
  import game_pkg::*;
#(
  parameter int TERMINAL_COUNT = DEFAULT_IMMUNE_FRAMES,
  parameter int BLINK_PERIOD   = DEFAULT_BLINK_FRAMES
) (
  input  logic clk,
  input  logic resetN,
  input  logic start,
  input  logic enable,
  input  logic startOfFrame,
  output logic terminalCount,
  output logic blinkPhase
);

  localparam logic [FRAME_CNT_W-1:0] c_TERMINAL   = FRAME_CNT_W'(TERMINAL_COUNT);
  localparam logic [FRAME_CNT_W-1:0] c_BLINK_LAST = FRAME_CNT_W'(BLINK_PERIOD - 1);

  logic [FRAME_CNT_W-1:0] r_frameCnt;
  logic [FRAME_CNT_W-1:0] r_blinkCnt;
  logic                   r_blinkPhase;
  logic                   w_frameTick;
  logic                   w_atTerminal;

  assign w_frameTick  = enable && startOfFrame;
  assign w_atTerminal = (r_frameCnt == c_TERMINAL);

  // start wins over a coincident frame pulse so the entry frame is never counted.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_frameCnt <= '0;
    end else if (start) begin
      r_frameCnt <= '0;
    end else if (w_frameTick && !w_atTerminal) begin
      r_frameCnt <= r_frameCnt + FRAME_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (start) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (w_frameTick) begin
      if (r_blinkCnt == c_BLINK_LAST) begin
        r_blinkCnt   <= '0;
        r_blinkPhase <= ~r_blinkPhase;
      end else begin
        r_blinkCnt <= r_blinkCnt + FRAME_CNT_W'(1);
      end
    end
  end

  assign terminalCount = w_atTerminal;
  assign blinkPhase    = r_blinkPhase;

endmodule

`default_nettype wire

// File: rtl/hit_manager.sv
// ============================================================================
// Module      : hit_manager
// Description : Player hit handling: one life-loss request per hit, timed
//               invulnerability with blinking sprite, sticky game over.
//               Optional feature macro: GOD_MODE_EN (adds input godMode).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hit_manager
  import game_pkg::*;
#(
  parameter int IMMUNE_FRAMES = DEFAULT_IMMUNE_FRAMES,
  parameter int BLINK_FRAMES  = DEFAULT_BLINK_FRAMES
) (
  input  logic       clk,
  input  logic       resetN,
`ifdef GOD_MODE_EN
  input  logic       godMode,
`endif
  input  logic       startOfFrame,
  input  logic       collision,
  input  logic [3:0] remainingLives,
  output logic       decreaseLife,
  output logic       immortal,
  output logic       playerVisible,
  output logic       gameOver
);

  hit_state_t r_state;
  hit_state_t w_nextState;
  logic       w_god;
  logic       w_noLives;
  logic       w_timerStart;
  logic       w_timerEnable;
  logic       w_terminal;
  logic       w_blinkPhase;

`ifdef GOD_MODE_EN
  assign w_god = godMode;
`else
  assign w_god = 1'b0;
`endif

  assign w_noLives     = (remainingLives == 4'd0);
  // The timer is cleared on the HIT->IMMUNE edge and only counts inside IMMUNE.
  assign w_timerStart  = (r_state == HIT);
  assign w_timerEnable = (r_state == IMMUNE);

  frame_timer #(
    .TERMINAL_COUNT (IMMUNE_FRAMES),
    .BLINK_PERIOD   (BLINK_FRAMES)
  ) u_frame_timer (
    .clk           (clk),
    .resetN        (resetN),
    .start         (w_timerStart),
    .enable        (w_timerEnable),
    .startOfFrame  (startOfFrame),
    .terminalCount (w_terminal),
    .blinkPhase    (w_blinkPhase)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= VULNERABLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      VULNERABLE: begin
        if (w_noLives) begin
          w_nextState = DEAD;
        end else if (collision && !w_god) begin
          w_nextState = HIT;
        end
      end
      HIT: begin
        w_nextState = IMMUNE;
      end
      IMMUNE: begin
        if (w_noLives) begin
          w_nextState = DEAD;
        end else if (w_terminal) begin
          w_nextState = VULNERABLE;
        end
      end
      DEAD: begin
        w_nextState = DEAD;
      end
      default: begin
        w_nextState = VULNERABLE;
      end
    endcase
  end

  always_comb begin
    decreaseLife  = (r_state == HIT);
    immortal      = is_immortal_state(r_state) || w_god;
    gameOver      = (r_state == DEAD);
    playerVisible = 1'b1;
    case (r_state)
      IMMUNE:  playerVisible = ~w_blinkPhase;
      DEAD:    playerVisible = 1'b0;
      default: playerVisible = 1'b1;
    endcase
  end

endmodule

`default_nettype wire
